rx_fifo: RTL and testbench
==========================

# rx_fifo

Receive-side buffer of the UART16550 core. It sits between the receiver path (byte plus parity status, strobed once per frame) and the host register interface (RBR read, LSR read). It provides a 16-entry FIFO, or a single holding register when FIFOs are disabled. It also generates overrun, per-byte parity error, trigger-level and character-timeout status.

## Interface
- DEPTH, 16, FIFO entries; power of two.
- TIMEOUT_BITS, 40, bit-times without push or pop before the character timeout (four 10-bit characters).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous, active-low reset.
- word_length  input  2  data bits = 5 + word_length; stored byte is masked to these bits, upper bits 0.
- baud_rate_cnt  input  16  clocks per bit-time; 0 is treated as 1.
- fifo_en  input  1  1 = FIFO mode, 0 = single holding register.
- fifo_clear  input  1  one-cycle pulse, flush contents.
- trigger_level  input  2  00/01/10/11 = 1/4/8/14 bytes.
- pi_rx_data  input  8  received byte.
- pi_parity_error  input  1  parity error of pi_rx_data.
- pi_rx_flag  input  1  one-cycle push strobe.
- read_flag  input  1  one-cycle pulse, host read of RBR (pop).
- lsr_read  input  1  one-cycle pulse, host read of LSR.
- po_rx_data  output  8  head byte; 8'h00 when empty.
- parity_error  output  1  parity flag of head byte; 0 when empty.
- data_ready  output  1  count != 0.
- overrun_error  output  1  sticky overrun.
- fifo_error  output  1  at least one stored entry carries a parity error.
- trigger_int  output  1  fifo_en and count >= trigger level.
- timeout_int  output  1  character timeout pending.
- fifo_count  output  5  number of stored entries (0..16).

## Operation
- Storage: 9-bit entries {parity, data}; rd_ptr/wr_ptr 4-bit wrap modulo DEPTH; count 5-bit.
- Push, FIFO mode: on pi_rx_flag, store the masked byte at wr_ptr. If count == 16 and no pop occurs in the same cycle, discard the byte and set overrun_error.
- Push, non-FIFO mode: effective depth 1. A push while count == 1 overwrites the entry and sets overrun_error, unless read_flag occurs in the same cycle.
- Pop: on read_flag with count != 0, advance rd_ptr and decrement count. With count == 0, read_flag is ignored.
- Simultaneous push and pop: both happen and count is unchanged. When full, this is not an overrun. When empty, the push wins and count becomes 1.
- overrun_error: cleared by lsr_read. If a set event coincides with lsr_read, the flag remains 1. fifo_clear does not affect it.
- fifo_error: maintained as a 5-bit counter of stored entries with parity = 1, so fifo_error = (pe_count != 0). Discarded bytes are not counted.
- fifo_clear, or any change of fifo_en (edge-detected internally): set ptrs, count and pe_count to 0 and clear timeout_int. If this coincides with a push, the clear wins and the byte is dropped.
- Timeout timer (FIFO mode only):
  - A clock-divider counter produces a bit tick every max(baud_rate_cnt,1) clocks.
  - A 6-bit tick counter increments on each bit tick while count != 0.
  - Both counters reset on push, on pop, when count == 0, and on flush.
  - When the tick counter reaches TIMEOUT_BITS, timeout_int sets.
  - timeout_int clears on pop, push, flush, or fifo_en = 0.
- States are implicit: EMPTY (count 0), PARTIAL, FULL (count 16). Transitions happen only through push, pop and flush as above.

## Timing
- Reset values: po_rx_data 0, parity_error 0, data_ready 0, overrun_error 0, fifo_error 0, trigger_int 0, timeout_int 0, fifo_count 0. Pointers, counters and timers are 0.
- Push latency: for a pi_rx_flag at edge N, data_ready, fifo_count and po_rx_data (when previously empty) update after edge N, so they are valid in cycle N+1.
- Pop latency: after a read_flag at edge N, the next head byte is visible in cycle N+1.
- po_rx_data, parity_error, trigger_int and data_ready are combinational from registered state. overrun_error, timeout_int and fifo_error derive from registers.
- Timeout assertion: exactly TIMEOUT_BITS × max(baud_rate_cnt,1) clocks after the last push or pop, ±1 clock.

## Test plan
- Reset, fifo_en = 1, push 0xA5, 0x3C with word_length = 3 -> data_ready = 1, fifo_count = 2, po_rx_data = 0xA5. After read_flag: po_rx_data = 0x3C, count = 1.
- Push 17 bytes 0x00..0x10, then lsr_read -> overrun_error = 1 after the 17th byte, count = 16, head 0x00. 0x10 is lost. overrun_error = 0 after lsr_read.
- word_length = 0, push 0xFF with pi_parity_error = 1 -> po_rx_data = 0x1F, parity_error = 1, fifo_error = 1. Pop -> fifo_error = 0.
- trigger_level = 01, push 3 bytes -> trigger_int = 0. 4th push -> trigger_int = 1.
- baud_rate_cnt = 4, push 1 byte, idle -> timeout_int rises after 160 ±1 clocks. read_flag clears it.
- fifo_en = 0: push 0x11, push 0x22 without a read -> po_rx_data = 0x22, overrun_error = 1, count = 1. Toggle fifo_en -> count = 0, data_ready = 0.

Source files
------------

// File: rtl/rx_fifo_if.sv
// ============================================================================
//  Module   : rx_fifo_if
//  Purpose  : Bundles the receiver-side push port, the host-side RBR/LSR
//             access strobes, the configuration inputs and the status outputs
//             of the UART receive FIFO.
//  Modports : master - receiver/host side (drives data, strobes, config)
//             slave  - the rx_fifo itself (drives head byte and status)
//  Signals  : word_length, baud_rate_cnt, fifo_en, fifo_clear, trigger_level,
//             pi_rx_data, pi_parity_error, pi_rx_flag, read_flag, lsr_read
//             (master -> slave); po_rx_data, parity_error, data_ready,
//             overrun_error, fifo_error, trigger_int, timeout_int, fifo_count
//             (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]    word_length;
    logic [15:0]   baud_rate_cnt;
    logic          fifo_en;
    logic          fifo_clear;
    logic [1:0]    trigger_level;
    logic [7:0]    pi_rx_data;
    logic          pi_parity_error;
    logic          pi_rx_flag;
    logic          read_flag;
    logic          lsr_read;

    logic [7:0]    po_rx_data;
    logic          parity_error;
    logic          data_ready;
    logic          overrun_error;
    logic          fifo_error;
    logic          trigger_int;
    logic          timeout_int;
    logic [CW-1:0] fifo_count;

    modport master (
        output word_length, baud_rate_cnt, fifo_en, fifo_clear, trigger_level,
        output pi_rx_data, pi_parity_error, pi_rx_flag, read_flag, lsr_read,
        input  po_rx_data, parity_error, data_ready, overrun_error,
        input  fifo_error, trigger_int, timeout_int, fifo_count
    );

    modport slave (
        input  word_length, baud_rate_cnt, fifo_en, fifo_clear, trigger_level,
        input  pi_rx_data, pi_parity_error, pi_rx_flag, read_flag, lsr_read,
        output po_rx_data, parity_error, data_ready, overrun_error,
        output fifo_error, trigger_int, timeout_int, fifo_count
    );

endinterface

`default_nettype wire

// File: rtl/rx_fifo.sv
// ============================================================================
//  Module   : rx_fifo
//  Purpose  : UART16550 receive buffer. 16-entry FIFO of {parity, data}
//             entries (or a single holding register when FIFOs are disabled)
//             with overrun, per-byte parity, trigger-level and character
//             timeout status.
//  Ports    : clk   - core clock
//             rst_n - asynchronous active-low reset
//             bus   - rx_fifo_if.slave (config, push/pop strobes, status)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_fifo #(
    parameter int DEPTH        = 16,
    parameter int TIMEOUT_BITS = 40
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    rx_fifo_if.slave    bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_DEPTH   = CW'(DEPTH);
    localparam logic [5:0]    c_TO_BITS = 6'(TIMEOUT_BITS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_pe_count;
    logic          r_overrun;
    logic          r_timeout;
    logic          r_fifo_en_q;
    logic [15:0]   r_div;
    logic [5:0]    r_ticks;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [7:0]    w_mask;
    logic [8:0]    w_wdata;
    logic [8:0]    w_head;
    logic          w_empty;
    logic          w_at_limit;
    logic          w_flush;
    logic          w_push;
    logic          w_pop;
    logic          w_ovr_event;
    logic          w_store;
    logic          w_overwrite;
    logic          w_pe_inc;
    logic          w_pe_dec;
    logic [15:0]   w_baud;
    logic          w_tick;
    logic          w_tmr_clr;
    logic          w_to_clr;
    logic [CW-1:0] w_trig;

    // Data bits = 5 + word_length; unused upper bits are stored as 0.
    assign w_mask  = 8'hFF >> (2'd3 - bus.word_length);
    assign w_wdata = {bus.pi_parity_error, bus.pi_rx_data & w_mask};
    assign w_head  = r_mem[r_rd_ptr];
    assign w_empty = (r_count == '0);

    // Holding-register mode behaves as a depth-1 FIFO.
    assign w_at_limit = bus.fifo_en ? (r_count == c_DEPTH) : (r_count == CW'(1));

    // Any change of fifo_en flushes exactly like fifo_clear.
    assign w_flush = bus.fifo_clear | (bus.fifo_en ^ r_fifo_en_q);

    // Flush dominates both push and pop.
    assign w_push = bus.pi_rx_flag & ~w_flush;
    assign w_pop  = bus.read_flag & ~w_empty & ~w_flush;

    // A push at the limit without a same-cycle pop is an overrun: the byte
    // is dropped in FIFO mode, and replaces the held byte otherwise.
    assign w_ovr_event = w_push & w_at_limit & ~w_pop;
    assign w_store     = w_push & ~w_ovr_event;
    assign w_overwrite = w_ovr_event & ~bus.fifo_en;

    // Overwrite and pop are mutually exclusive, so at most one old entry
    // leaves and at most one new entry arrives per cycle.
    assign w_pe_inc = (w_store | w_overwrite) & bus.pi_parity_error;
    assign w_pe_dec = (w_pop | w_overwrite) & w_head[8];

    // ------------------------------------------------------------------
    // Storage array (no reset needed: contents are gated by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end else if (w_overwrite) begin
            r_mem[r_rd_ptr] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, parity-entry count, overrun
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_pe_count  <= '0;
            r_overrun   <= 1'b0;
            r_fifo_en_q <= 1'b0;
        end else begin
            r_fifo_en_q <= bus.fifo_en;

            if (w_flush) begin
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_pe_count <= '0;
            end else begin
                if (w_store) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count    <= r_count + CW'(w_store) - CW'(w_pop);
                r_pe_count <= r_pe_count + CW'(w_pe_inc) - CW'(w_pe_dec);
            end

            // A new overrun wins over the LSR read that would clear it.
            if (w_ovr_event) begin
                r_overrun <= 1'b1;
            end else if (bus.lsr_read) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Character timeout: bit-time divider plus saturating bit counter
    // ------------------------------------------------------------------
    assign w_baud    = (bus.baud_rate_cnt == 16'd0) ? 16'd1 : bus.baud_rate_cnt;
    assign w_tick    = (r_div == (w_baud - 16'd1));
    assign w_to_clr  = bus.pi_rx_flag | w_pop | w_flush | ~bus.fifo_en;
    assign w_tmr_clr = w_to_clr | w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_ticks   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_tmr_clr) begin
                r_div   <= '0;
                r_ticks <= '0;
            end else if (w_tick) begin
                r_div <= '0;
                if (r_ticks != c_TO_BITS) begin
                    r_ticks <= r_ticks + 6'd1;
                end
            end else begin
                r_div <= r_div + 16'd1;
            end

            // Set on the tick that completes the last bit-time, so the flag
            // rises exactly TIMEOUT_BITS bit-times after the last activity.
            if (w_to_clr) begin
                r_timeout <= 1'b0;
            end else if (!w_tmr_clr && w_tick && (r_ticks == c_TO_BITS - 6'd1)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_trig = CW'(1);
        case (bus.trigger_level)
            2'b00:   w_trig = CW'(1);
            2'b01:   w_trig = CW'(4);
            2'b10:   w_trig = CW'(8);
            default: w_trig = CW'(14);
        endcase
    end

    assign bus.po_rx_data    = w_empty ? 8'h00 : w_head[7:0];
    assign bus.parity_error  = ~w_empty & w_head[8];
    assign bus.data_ready    = ~w_empty;
    assign bus.overrun_error = r_overrun;
    assign bus.fifo_error    = (r_pe_count != '0);
    assign bus.trigger_int   = bus.fifo_en & (r_count >= w_trig);
    assign bus.timeout_int   = r_timeout;
    assign bus.fifo_count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_rx_fifo.sv
// ============================================================================
//  Module   : tb_rx_fifo
//  Purpose  : Self-checking bench for rx_fifo. A queue-based reference model
//             tracks contents, overrun and idle time; a compare process checks
//             every status output on each falling edge, and directed
//             sequences pin hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_fifo;

    logic clk;
    logic rst_n;

    rx_fifo_if #(.DEPTH(16)) bus ();

    rx_fifo #(.DEPTH(16), .TIMEOUT_BITS(40)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [8:0] m_q[$];
    bit         m_ovr;
    bit         m_to;
    bit         m_prev_en;
    int         m_since;

    function automatic int trig_bytes(input logic [1:0] lvl);
        case (lvl)
            2'd0: return 1;
            2'd1: return 4;
            2'd2: return 8;
            default: return 14;
        endcase
    endfunction

    function automatic int tmo_clocks();
        int b;
        b = (bus.baud_rate_cnt == 0) ? 1 : int'(bus.baud_rate_cnt);
        return 40 * b;
    endfunction

    always @(posedge clk) begin
        bit   flush, pop, setovr, act;
        int   n0, lim, bytes_mod;
        logic [8:0] b;
        if (!rst_n) begin
            m_q.delete();
            m_ovr = 0; m_to = 0; m_prev_en = 0; m_since = 0;
        end else begin
            flush     = bus.fifo_clear || (bus.fifo_en != m_prev_en);
            m_prev_en = bus.fifo_en;
            n0        = m_q.size();
            pop       = bus.read_flag && (n0 != 0) && !flush;
            setovr    = 0;
            if (flush) begin
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                if (bus.pi_rx_flag) begin
                    bytes_mod = 1 << (5 + int'(bus.word_length));
                    b = {bus.pi_parity_error, 8'(int'(bus.pi_rx_data) % bytes_mod)};
                    lim = bus.fifo_en ? 16 : 1;
                    if (n0 == lim && !pop) begin
                        setovr = 1;
                        if (!bus.fifo_en) m_q[0] = b;
                    end else begin
                        m_q.push_back(b);
                    end
                end
            end
            if (setovr) m_ovr = 1;
            else if (bus.lsr_read) m_ovr = 0;

            act = bus.pi_rx_flag || pop || flush || !bus.fifo_en;
            if (act) m_to = 0;
            if (act || n0 == 0) m_since = 0;
            else begin
                m_since++;
                if (m_since == tmo_clocks()) m_to = 1;
            end
        end
    end

    // Continuous comparison on the falling edge.
    always @(negedge clk) begin
        int n, d;
        bit pe_any;
        if (rst_n) begin
            n = m_q.size();
            pe_any = 0;
            foreach (m_q[i]) if (m_q[i][8]) pe_any = 1;
            chk("cmp_head",    32'(bus.po_rx_data),    (n != 0) ? 32'(m_q[0][7:0]) : 32'd0);
            chk("cmp_pe",      32'(bus.parity_error),  (n != 0) ? 32'(m_q[0][8])   : 32'd0);
            chk("cmp_ready",   32'(bus.data_ready),    32'(n != 0));
            chk("cmp_count",   32'(bus.fifo_count),    32'(n));
            chk("cmp_overrun", 32'(bus.overrun_error), 32'(m_ovr));
            chk("cmp_fifoerr", 32'(bus.fifo_error),    32'(pe_any));
            chk("cmp_trigger", 32'(bus.trigger_int),   32'(bus.fifo_en && n >= trig_bytes(bus.trigger_level)));
            d = m_since - tmo_clocks();
            if (d < -1 || d > 1)
                chk("cmp_timeout", 32'(bus.timeout_int), 32'(m_to));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [7:0] d, input logic pe);
        bus.pi_rx_data = d; bus.pi_parity_error = pe; bus.pi_rx_flag = 1'b1;
        tick();
        bus.pi_rx_flag = 1'b0; bus.pi_parity_error = 1'b0;
    endtask

    task automatic pop();
        bus.read_flag = 1'b1; tick(); bus.read_flag = 1'b0;
    endtask

    task automatic clear();
        bus.fifo_clear = 1'b1; tick(); bus.fifo_clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.word_length = 2'd3; bus.baud_rate_cnt = 16'd4; bus.fifo_en = 1'b1;
        bus.fifo_clear = 1'b0; bus.trigger_level = 2'd0; bus.pi_rx_data = 8'h00;
        bus.pi_parity_error = 1'b0; bus.pi_rx_flag = 1'b0; bus.read_flag = 1'b0;
        bus.lsr_read = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_head",    32'(bus.po_rx_data), 32'h0);
        chk("rst_pe",      32'(bus.parity_error), 32'h0);
        chk("rst_ready",   32'(bus.data_ready), 32'h0);
        chk("rst_overrun", 32'(bus.overrun_error), 32'h0);
        chk("rst_fifoerr", 32'(bus.fifo_error), 32'h0);
        chk("rst_trigger", 32'(bus.trigger_int), 32'h0);
        chk("rst_timeout", 32'(bus.timeout_int), 32'h0);
        chk("rst_count",   32'(bus.fifo_count), 32'h0);

        rst_n = 1'b1;
        repeat (2) tick();

        // Basic push / pop
        push(8'hA5, 1'b0);
        push(8'h3C, 1'b0);
        chk("t1_ready", 32'(bus.data_ready), 32'd1);
        chk("t1_count", 32'(bus.fifo_count), 32'd2);
        chk("t1_head",  32'(bus.po_rx_data), 32'hA5);
        pop();
        chk("t1_head2", 32'(bus.po_rx_data), 32'h3C);
        chk("t1_count2", 32'(bus.fifo_count), 32'd1);
        pop();
        pop();   // read while empty is ignored
        chk("t1_empty", 32'(bus.fifo_count), 32'd0);

        // Simultaneous push and pop while empty: push wins
        bus.read_flag = 1'b1;
        push(8'h77, 1'b0);
        bus.read_flag = 1'b0;
        chk("t1_pp_empty_cnt",  32'(bus.fifo_count), 32'd1);
        chk("t1_pp_empty_head", 32'(bus.po_rx_data), 32'h77);
        clear();

        // Overflow: 17 pushes
        for (int i = 0; i < 17; i++) begin
            push(8'(i), 1'b0);
            if (i == 15) chk("t2_no_ovr_at_16", 32'(bus.overrun_error), 32'd0);
        end
        chk("t2_overrun", 32'(bus.overrun_error), 32'd1);
        chk("t2_count",   32'(bus.fifo_count), 32'd16);
        chk("t2_head",    32'(bus.po_rx_data), 32'h00);
        bus.lsr_read = 1'b1; tick(); bus.lsr_read = 1'b0;
        chk("t2_ovr_clr", 32'(bus.overrun_error), 32'd0);
        // Push + pop while full is not an overrun
        bus.read_flag = 1'b1;
        push(8'h55, 1'b0);
        bus.read_flag = 1'b0;
        chk("t2_pp_full_ovr",  32'(bus.overrun_error), 32'd0);
        chk("t2_pp_full_cnt",  32'(bus.fifo_count), 32'd16);
        chk("t2_pp_full_head", 32'(bus.po_rx_data), 32'h01);
        // Set coinciding with LSR read keeps the flag
        bus.lsr_read = 1'b1;
        push(8'h66, 1'b0);
        bus.lsr_read = 1'b0;
        chk("t2_ovr_vs_lsr", 32'(bus.overrun_error), 32'd1);
        clear();
        chk("t2_clr_count", 32'(bus.fifo_count), 32'd0);
        chk("t2_clr_keeps_ovr", 32'(bus.overrun_error), 32'd1);
        bus.lsr_read = 1'b1; tick(); bus.lsr_read = 1'b0;

        // Word-length masking and parity
        bus.word_length = 2'd0;
        push(8'hFF, 1'b1);
        chk("t3_head",    32'(bus.po_rx_data), 32'h1F);
        chk("t3_pe",      32'(bus.parity_error), 32'd1);
        chk("t3_fifoerr", 32'(bus.fifo_error), 32'd1);
        pop();
        chk("t3_fifoerr_clr", 32'(bus.fifo_error), 32'd0);
        bus.word_length = 2'd3;

        // Trigger level 4
        bus.trigger_level = 2'd1;
        for (int i = 0; i < 3; i++) push(8'(8'h40 + i), 1'b0);
        chk("t4_trig_3", 32'(bus.trigger_int), 32'd0);
        push(8'h43, 1'b0);
        chk("t4_trig_4", 32'(bus.trigger_int), 32'd1);
        clear();
        bus.trigger_level = 2'd0;

        // Character timeout: 40 * 4 = 160 clocks after the push
        push(8'h99, 1'b0);
        repeat (158) tick();
        chk("t5_to_early", 32'(bus.timeout_int), 32'd0);
        repeat (3) tick();
        chk("t5_to_set", 32'(bus.timeout_int), 32'd1);
        pop();
        chk("t5_to_clr", 32'(bus.timeout_int), 32'd0);

        // Holding-register mode
        bus.fifo_en = 1'b0;
        tick();
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        chk("t6_head",    32'(bus.po_rx_data), 32'h22);
        chk("t6_overrun", 32'(bus.overrun_error), 32'd1);
        chk("t6_count",   32'(bus.fifo_count), 32'd1);
        bus.fifo_en = 1'b1;
        tick();
        chk("t6_toggle_count", 32'(bus.fifo_count), 32'd0);
        chk("t6_toggle_ready", 32'(bus.data_ready), 32'd0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
